// File: rtl/rs232_pkg.sv
// Shared RS232 definitions: FSM state encoding, frame geometry and line levels.
// Used by both the transmit and receive halves of the link.
package rs232_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rs232_state_e;

  localparam int DATA_BITS = 8;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rs232_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_end_o on the last count.
// Synchronous clear restarts the period; reusable by an oversampling receiver.
module rs232_baud_gen #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_end_o = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || bit_end_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rs232_tx.sv
// RS232 transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit(s).
// Build option: define RS232_TX_PARITY_EN to insert the PARITY state between DATA and STOP.
module rs232_tx
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] TData,
  input  logic                 TValid,
  output logic                 TReady,
  output logic                 Tx,
  output logic                 Busy
);

  rs232_state_e         state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 bit_end, handshake, last_stop;
`ifdef RS232_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign handshake = TValid && TReady;
  assign last_stop = (state_q == STOP) && bit_end && (stop_cnt_q == 1'(STOP_BITS - 1));

  rs232_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (handshake),
    .bit_end_o(bit_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= LINE_IDLE;
      busy_q     <= 1'b0;
`ifdef RS232_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
`ifdef RS232_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = '0;
    stop_cnt_d = 1'b0;
`ifdef RS232_TX_PARITY_EN
    parity_d   = handshake ? even_parity(TData) : parity_q;
`endif
    if (handshake) shift_d = TData;
    case (state_q)
      IDLE:  if (handshake) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA: begin
        bit_cnt_d = bit_end ? bit_cnt_q + 3'd1 : bit_cnt_q;
        if (bit_end) shift_d = shift_q >> 1;
        if (bit_end && bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef RS232_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef RS232_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: begin
        stop_cnt_d = bit_end ? ~stop_cnt_q : stop_cnt_q;
        if (last_stop) state_d = handshake ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is registered from the current state, so Tx trails the state by one clk.
  always_comb begin
    TReady = !reset && ((state_q == IDLE) || last_stop);
    busy_d = (state_q != IDLE);
    case (state_q)
      START:  tx_d = LINE_START;
      DATA:   tx_d = shift_q[0];
`ifdef RS232_TX_PARITY_EN
      PARITY: tx_d = parity_q;
`endif
      STOP:   tx_d = LINE_STOP;
      default: tx_d = LINE_IDLE;
    endcase
  end

  assign Tx   = tx_q;
  assign Busy = busy_q;

endmodule

// File: doc/rs232_tx.md
Name: rs232_tx

Overview:
- Serial UART transmitter; converts an 8-bit parallel byte into an RS232 frame on line Tx: start bit 0, 8 data bits LSB first, then stop bit(s) 1.
- Sits between the on-chip byte source and the board TX pin; this is the transmit half of the team's RS232 link.
- Bit period is CLKS_PER_BIT clk cycles. The default of 1 gives one bit per clk, which matches the one-bit-per-clock receiver on the same link.

Parameters:
- CLKS_PER_BIT, 1, clk cycles per serial bit; legal range ≥1.
- STOP_BITS, 1, number of stop bit periods; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- TData  input  8  byte to send; sampled only on handshake.
- TValid  input  1  source has a byte on TData.
- TReady  output  1  block can accept a byte this cycle.
- Tx  output  1  serial line, registered; idle high.
- Busy  output  1  frame in progress (any state other than IDLE).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset); the polarity and synchronicity are fixed.
- Reset: state IDLE, Tx=1, Busy=0, counters 0, shift register 0. TReady=0 while reset=1, and 1 from the first cycle after reset deasserts.
- Reset mid-frame: the frame is abandoned. Tx=1 at the next edge; no partial bits follow.
- Handshake: a transfer occurs when TValid && TReady at a rising edge; TData is latched into the shift register on that edge. TValid without TReady is ignored; the source holds TData and TValid.
- TReady=1 in IDLE, and during the final clk of the last stop bit period (back-to-back support). It is 0 otherwise.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: Tx=1. On handshake, go to START.
  - START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: Tx=shift[0]. Shift right at the end of each bit period. After 8 periods go to PARITY (if compiled) or STOP.
  - STOP: Tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end: if a handshake occurred on that last cycle, go to START; otherwise go to IDLE.
- Latency: Tx drops to 0 on the edge following the handshake edge (1 cycle).
- Frame length, from the first start cycle to the last stop cycle inclusive: (1+8+STOP_BITS)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT more when the parity feature is compiled in.
- Baud counter:
  - Width is max(1, clog2(CLKS_PER_BIT)); counts 0..CLKS_PER_BIT-1.
  - Wraps to 0 at the bit-period end and clears on entry to START.
  - With CLKS_PER_BIT=1, every cycle is a bit end.
- Bit counter: 3 bits, counts data bits 0..7; the exit condition is at count 7 on bit end. No wrap is visible externally.
- Tx and Busy are driven from registers; there is no combinational path from TData to Tx.
- Back-to-back frames: stop bit(s) go directly into the next start bit with no extra idle bit.

Optional Feature:
- Macro: RS232_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - Tx = XOR of the 8 latched data bits (even parity), held for one bit period.
  - The parity value is computed at the handshake edge and registered.
- Undefined: the PARITY state, the parity register and its logic are absent; DATA goes directly to STOP.

Decomposition:
- Package rs232_pkg holds:
  - the state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3-bit);
  - DATA_BITS=8;
  - the idle/start/stop line-level constants.
- The package is shared with the receive side.
- Sub-module rs232_baud_gen: CLKS_PER_BIT counter with a synchronous clear; outputs a one-cycle bit_end pulse. It is reusable by the receiver when oversampling is added.

Test Plan:
- Single byte, CLKS_PER_BIT=1, TData=0xA5, 1-cycle TValid pulse: Tx=1 on the handshake edge, then 0,1,0,1,0,0,1,0,1,1 on the following 10 cycles. TReady is 0 from the cycle after the handshake until the last stop cycle. Busy is high for exactly 10 cycles.
- CLKS_PER_BIT=4, TData=0x00: start plus 8 data bits give Tx=0 for 36 consecutive cycles, then Tx=1 for 4 cycles. Frame total 40 cycles.
- Back-to-back, CLKS_PER_BIT=1, TValid held high with 0x55 then 0x0F: the second start bit immediately follows the first stop bit, with no idle cycle. Tx stream: 0,1,0,1,0,1,0,1,0,1,0,1,1,1,1,0,0,0,0,1.
- Reset asserted during the 4th data bit of 0xFF: Tx=1 at the next edge, Busy=0, TReady=1 after reset deasserts. A following byte 0x81 is transmitted as a clean frame.
- STOP_BITS=2, CLKS_PER_BIT=2: two stop bit periods give Tx high for 4 cycles before the next start bit. TReady is high only during the final clk of that stop time.
- RS232_TX_PARITY_EN defined, TData=0x07: parity bit 1 (three ones) after the data bits. TData=0x03: parity bit 0. Frame length 11 bit periods.
